// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR and trap unit: CSR addresses,
// operation encodings, bit positions and the trap FSM state type.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_e;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MTIE_BIT = 7;
  localparam int MTIP_BIT = 7;

  localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;
  // Vectored mode jumps to base + 4 * cause code (7 for the machine timer).
  localparam logic [31:0] TIMER_VECTOR_OFFSET = 32'd28;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } intr_state_e;

  function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_val,
                                            logic [31:0] operand);
    logic [31:0] res;
    res = old_val;
    case (op)
      CSR_WRITE: res = operand;
      CSR_SET:   res = old_val | operand;
      CSR_CLEAR: res = old_val & ~operand;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage with a combinational read mux and Zicsr
// write/set/clear handling; trap entry and mret update fields directly.
module csr_regfile
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] csr_addr_i,
  input  logic [1:0]  csr_op_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        csr_en_i,
  input  logic        trap_enter_i,
  input  logic [31:0] trap_pc_i,
  input  logic        mret_i,
  input  logic        mtip_i,
  output logic [31:0] csr_rdata_o,
  output logic        mstatus_mie_o,
  output logic        mie_mtie_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_mtie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;

  csr_op_e     op;
  logic        do_write;
  logic [31:0] wval;

  always_comb begin
    csr_rdata_o = 32'h0;
    case (csr_addr_i)
      CSR_MSTATUS: begin
        csr_rdata_o[MIE_BIT]  = mstatus_mie;
        csr_rdata_o[MPIE_BIT] = mstatus_mpie;
      end
      CSR_MIE:    csr_rdata_o[MTIE_BIT] = mie_mtie;
      CSR_MTVEC:  csr_rdata_o = mtvec;
      CSR_MEPC:   csr_rdata_o = mepc;
      CSR_MCAUSE: csr_rdata_o = mcause;
      CSR_MIP:    csr_rdata_o[MTIP_BIT] = mtip_i;
      default:    csr_rdata_o = 32'h0;
    endcase
  end

  // Set/clear with a zero operand is a pure read and must not write.
  always_comb begin
    op       = csr_op_e'(csr_op_i);
    wval     = csr_apply(op, csr_rdata_o, csr_wdata_i);
    do_write = csr_en_i && (op != CSR_NONE) &&
               !(((op == CSR_SET) || (op == CSR_CLEAR)) && (csr_wdata_i == 32'h0));
  end

  // Later assignments take priority: mret and trap entry override a CSR write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mtvec        <= MTVEC_RESET;
      mepc         <= 32'h0;
      mcause       <= 32'h0;
    end else begin
      if (do_write) begin
        case (csr_addr_i)
          CSR_MSTATUS: begin
            mstatus_mie  <= wval[MIE_BIT];
            mstatus_mpie <= wval[MPIE_BIT];
          end
          CSR_MIE:    mie_mtie <= wval[MTIE_BIT];
          CSR_MTVEC:  mtvec    <= wval;
          CSR_MEPC:   mepc     <= wval & ~32'h3;
          CSR_MCAUSE: mcause   <= wval;
          default: ;
        endcase
      end
      if (mret_i) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
      if (trap_enter_i) begin
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
        mepc         <= trap_pc_i & ~32'h3;
        mcause       <= CAUSE_M_TIMER;
      end
    end
  end

  assign mstatus_mie_o = mstatus_mie;
  assign mie_mtie_o    = mie_mtie;
  assign mtvec_o       = mtvec;
  assign mepc_o        = mepc;

endmodule

// File: rtl/csr_intr_unit.sv
// Machine-mode CSR and timer-interrupt trap unit beside MEM/WB: latches the
// timer pending bit, decides trap entry / mret, and issues a PC redirect.
module csr_intr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        timer_intr_i,
  input  logic        instr_valid_i,
  input  logic [31:0] pc_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        is_mret_i,
  output logic [31:0] csr_rdata_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        trap_busy_o
);

  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

  intr_state_e state, state_next;
  logic [7:0]  flush_cnt, flush_cnt_next;
  logic        mtip;
  logic        mstatus_mie;
  logic        mie_mtie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        take_intr;
  logic        take_mret;
  logic        csr_en;
  logic [31:0] mtvec_base;
  logic [31:0] trap_target;

  // instr_valid_i qualifies every MEM/WB input for one cycle; there is no
  // back-pressure, and while FLUSH is active it is ignored entirely.
  assign take_intr = (state == RUN) && instr_valid_i && mtip && mstatus_mie && mie_mtie;
  assign take_mret = (state == RUN) && instr_valid_i && is_mret_i && !take_intr;
  assign csr_en    = (state == RUN) && instr_valid_i && !take_intr;

  assign mtvec_base  = mtvec & ~32'h3;
  assign trap_target = (mtvec[1:0] == 2'b01) ? (mtvec_base + TIMER_VECTOR_OFFSET)
                                             : mtvec_base;

  csr_regfile #(
    .MTVEC_RESET(MTVEC_RESET)
  ) u_regfile (
    .clk          (clk),
    .reset        (reset),
    .csr_addr_i   (csr_addr_i),
    .csr_op_i     (csr_op_i),
    .csr_wdata_i  (csr_wdata_i),
    .csr_en_i     (csr_en),
    .trap_enter_i (take_intr),
    .trap_pc_i    (pc_i),
    .mret_i       (take_mret),
    .mtip_i       (mtip),
    .csr_rdata_o  (csr_rdata_o),
    .mstatus_mie_o(mstatus_mie),
    .mie_mtie_o   (mie_mtie),
    .mtvec_o      (mtvec),
    .mepc_o       (mepc)
  );

  // A timer pulse in the trap-entry cycle keeps the bit set.
  always_ff @(posedge clk) begin
    if (reset)             mtip <= 1'b0;
    else if (timer_intr_i) mtip <= 1'b1;
    else if (take_intr)    mtip <= 1'b0;
  end

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      RUN: begin
        if (take_intr || take_mret) begin
          state_next     = FLUSH;
          flush_cnt_next = FLUSH_LAST;
        end
      end
      FLUSH: begin
        if (flush_cnt == 8'd0) state_next = RUN;
        else                   flush_cnt_next = flush_cnt - 8'd1;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      flush_cnt     <= 8'd0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= 32'h0;
    end else begin
      state      <= state_next;
      flush_cnt  <= flush_cnt_next;
      redirect_o <= take_intr || take_mret;
      if (take_intr)      redirect_pc_o <= trap_target;
      else if (take_mret) redirect_pc_o <= mepc;
    end
  end

  assign trap_busy_o = (state == FLUSH);

endmodule

// File: tb/tb_csr_intr_unit.sv
// Bench for csr_intr_unit: directed scenarios plus random traffic checked
// against a behavioural CSR/trap model and a redirect-target queue.
module tb_csr_intr_unit;

  localparam logic [31:0] MTVEC_RESET  = 32'h0000_0000;
  localparam int          FLUSH_CYCLES = 2;

  logic        clk;
  logic        reset;
  logic        timer_intr_i;
  logic        instr_valid_i;
  logic [31:0] pc_i;
  logic [1:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic        is_mret_i;
  logic [31:0] csr_rdata_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        trap_busy_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Reference model state
  bit          m_mie, m_mpie, m_mtie, m_pend, m_redir;
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  int          m_flush;

  csr_intr_unit #(
    .MTVEC_RESET (MTVEC_RESET),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .timer_intr_i (timer_intr_i),
    .instr_valid_i(instr_valid_i),
    .pc_i         (pc_i),
    .csr_op_i     (csr_op_i),
    .csr_addr_i   (csr_addr_i),
    .csr_wdata_i  (csr_wdata_i),
    .is_mret_i    (is_mret_i),
    .csr_rdata_o  (csr_rdata_o),
    .redirect_o   (redirect_o),
    .redirect_pc_o(redirect_pc_o),
    .trap_busy_o  (trap_busy_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(logic [11:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (a)
      12'h300: r = (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
      12'h304: r = m_mtie ? 32'h80 : 32'h0;
      12'h305: r = m_mtvec;
      12'h341: r = m_mepc;
      12'h342: r = m_mcause;
      12'h344: r = m_pend ? 32'h80 : 32'h0;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mtie = 0; m_pend = 0; m_redir = 0;
    m_mtvec = MTVEC_RESET; m_mepc = 0; m_mcause = 0; m_flush = 0;
    exp_q.delete();
  endtask

  // One clock edge of architectural behaviour, from the current inputs.
  task automatic model_edge();
    bit run, ti, tm, old_mie, old_mpie;
    logic [31:0] old_val, nv, target, old_mepc;
    run      = (m_flush == 0);
    ti       = run && instr_valid_i && m_pend && m_mie && m_mtie;
    tm       = run && instr_valid_i && is_mret_i && !ti;
    old_val  = model_read(csr_addr_i);
    old_mepc = m_mepc;
    old_mie  = m_mie;
    old_mpie = m_mpie;
    target   = {m_mtvec[31:2], 2'b00} + ((m_mtvec[1:0] == 2'd1) ? 32'd28 : 32'd0);
    if (run && instr_valid_i && !ti && csr_op_i != 2'd0 &&
        !(csr_op_i >= 2'd2 && csr_wdata_i == 32'h0)) begin
      if (csr_op_i == 2'd1)      nv = csr_wdata_i;
      else if (csr_op_i == 2'd2) nv = old_val | csr_wdata_i;
      else                       nv = old_val & ~csr_wdata_i;
      case (csr_addr_i)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mtie = nv[7];
        12'h305: m_mtvec = nv;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        default: ;
      endcase
    end
    if (tm) begin m_mie = old_mpie; m_mpie = 1; end
    if (ti) begin
      m_mepc = pc_i & ~32'h3; m_mcause = 32'h8000_0007;
      m_mpie = old_mie; m_mie = 0;
    end
    if (ti || tm) begin
      exp_q.push_back(ti ? target : old_mepc);
      m_flush = FLUSH_CYCLES;
    end else if (m_flush > 0) begin
      m_flush--;
    end
    m_redir = ti || tm;
    if (timer_intr_i) m_pend = 1;
    else if (ti)      m_pend = 0;
  endtask

  always @(posedge clk) begin
    if (reset) model_reset();
    else       model_edge();
  end

  // Scoreboard: redirect pulse, target from the queue, busy flag.
  always @(negedge clk) begin
    logic [31:0] want;
    checks++;
    if (redirect_o !== m_redir) begin
      errors++;
      $display("FAIL sb_redirect: got %b expected %b at %0t", redirect_o, m_redir, $time);
    end
    checks++;
    if (trap_busy_o !== (m_flush != 0)) begin
      errors++;
      $display("FAIL sb_busy: got %b expected %b at %0t", trap_busy_o, (m_flush != 0), $time);
    end
    if (m_redir && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      checks++;
      if (redirect_pc_o !== want) begin
        errors++;
        $display("FAIL sb_redirect_pc: got %h expected %h at %0t", redirect_pc_o, want, $time);
      end
    end
  end

  // Driver tasks
  task automatic drive(input bit v, input logic [31:0] pc, input logic [1:0] op,
                       input logic [11:0] a, input logic [31:0] wd,
                       input bit mret, input bit tmr);
    instr_valid_i = v; pc_i = pc; csr_op_i = op; csr_addr_i = a;
    csr_wdata_i = wd; is_mret_i = mret; timer_intr_i = tmr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 2'd0, 12'h0, 0, 0, 0);
  endtask

  task automatic peek(input logic [11:0] a);
    instr_valid_i = 0; csr_op_i = 2'd0; csr_addr_i = a; is_mret_i = 0; timer_intr_i = 0;
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] addrs[4];
    logic [31:0] exps[4];
    addrs = '{12'h305, 12'h300, 12'h304, 12'h344};
    exps  = '{MTVEC_RESET, 32'h0, 32'h0, 32'h0};
    reset = 1; idle(2); reset = 0;
    for (int i = 0; i < 4; i++) begin
      peek(addrs[i]);
      checks++;
      if (csr_rdata_o !== exps[i]) begin
        errors++;
        $display("FAIL reset_read_%h: got %h expected %h", addrs[i], csr_rdata_o, exps[i]);
      end
    end
  endtask

  task automatic test_trap_direct();
    logic [11:0] addrs[4];
    logic [31:0] exps[4];
    addrs = '{12'h341, 12'h342, 12'h300, 12'h344};
    exps  = '{32'h40, 32'h8000_0007, 32'h80, 32'h0};
    drive(1, 0, 2'd1, 12'h305, 32'h100, 0, 0);
    drive(1, 0, 2'd1, 12'h304, 32'h80, 0, 0);
    drive(1, 0, 2'd2, 12'h300, 32'h8, 0, 0);
    drive(0, 0, 2'd0, 12'h0, 0, 0, 1);
    drive(1, 32'h40, 2'd0, 12'h0, 0, 0, 0);
    checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h100) begin
      errors++;
      $display("FAIL direct_redirect: got %b/%h expected 1/00000100", redirect_o, redirect_pc_o);
    end
    idle(2);
    for (int i = 0; i < 4; i++) begin
      peek(addrs[i]);
      checks++;
      if (csr_rdata_o !== exps[i]) begin
        errors++;
        $display("FAIL after_trap_%h: got %h expected %h", addrs[i], csr_rdata_o, exps[i]);
      end
    end
  endtask

  task automatic test_masked();
    drive(0, 0, 2'd0, 12'h0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 32'h50 + 32'(4 * i), 2'd0, 12'h0, 0, 0, 0);
    checks++;
    if (redirect_o !== 1'b0) begin
      errors++;
      $display("FAIL masked_no_redirect: got %b expected 0", redirect_o);
    end
    peek(12'h344);
    checks++;
    if (csr_rdata_o !== 32'h80) begin
      errors++;
      $display("FAIL masked_mip: got %h expected 00000080", csr_rdata_o);
    end
    drive(1, 32'h5c, 2'd2, 12'h300, 32'h8, 0, 0);
    drive(1, 32'h60, 2'd0, 12'h0, 0, 0, 0);
    checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h100) begin
      errors++;
      $display("FAIL unmask_trap: got %b/%h expected 1/00000100", redirect_o, redirect_pc_o);
    end
    idle(2);
  endtask

  task automatic test_vectored();
    drive(1, 0, 2'd1, 12'h305, 32'h101, 0, 0);
    drive(1, 0, 2'd2, 12'h300, 32'h8, 0, 0);
    drive(0, 0, 2'd0, 12'h0, 0, 0, 1);
    drive(1, 32'h64, 2'd0, 12'h0, 0, 0, 0);
    checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h11C) begin
      errors++;
      $display("FAIL vectored_redirect: got %b/%h expected 1/0000011c", redirect_o, redirect_pc_o);
    end
    idle(2);
  endtask

  task automatic test_mret();
    drive(1, 0, 2'd1, 12'h341, 32'h44, 0, 0);
    // mret together with an mstatus write of 0: the mret update must win
    drive(1, 32'h70, 2'd1, 12'h300, 32'h0, 1, 0);
    checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h44) begin
      errors++;
      $display("FAIL mret_redirect: got %b/%h expected 1/00000044", redirect_o, redirect_pc_o);
    end
    drive(1, 32'h74, 2'd0, 12'h0, 0, 0, 1);
    checks++;
    if (redirect_o !== 1'b0 || trap_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_hold: got redirect %b busy %b expected 0 1", redirect_o, trap_busy_o);
    end
    drive(1, 32'h78, 2'd0, 12'h0, 0, 0, 0);
    checks++;
    if (redirect_o !== 1'b0 || trap_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_end: got redirect %b busy %b expected 0 0", redirect_o, trap_busy_o);
    end
    peek(12'h300);
    checks++;
    if (csr_rdata_o !== 32'h88) begin
      errors++;
      $display("FAIL mret_mstatus: got %h expected 00000088", csr_rdata_o);
    end
    drive(1, 32'h7c, 2'd0, 12'h0, 0, 0, 0);
    checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h11C) begin
      errors++;
      $display("FAIL post_flush_trap: got %b/%h expected 1/0000011c", redirect_o, redirect_pc_o);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 2'd2, 12'h300, 32'h8, 0, 0);
    drive(0, 0, 2'd0, 12'h0, 0, 0, 1);
    drive(1, 32'h80, 2'd0, 12'h0, 0, 0, 1);
    checks++;
    if (redirect_o !== 1'b1) begin
      errors++;
      $display("FAIL coincide_trap: got %b expected 1", redirect_o);
    end
    peek(12'h344);
    checks++;
    if (csr_rdata_o !== 32'h80) begin
      errors++;
      $display("FAIL coincide_mip: got %h expected 00000080", csr_rdata_o);
    end
    idle(2);
    drive(1, 32'h84, 2'd0, 12'h0, 0, 1, 0);
    checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h80) begin
      errors++;
      $display("FAIL second_mret: got %b/%h expected 1/00000080", redirect_o, redirect_pc_o);
    end
    idle(2);
    drive(1, 32'h88, 2'd0, 12'h0, 0, 0, 0);
    checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h11C) begin
      errors++;
      $display("FAIL second_trap: got %b/%h expected 1/0000011c", redirect_o, redirect_pc_o);
    end
    reset = 1;
    drive(0, 0, 2'd0, 12'h0, 0, 0, 0);
    reset = 0;
    checks++;
    if (trap_busy_o !== 1'b0 || redirect_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_flush: got busy %b redirect %b expected 0 0", trap_busy_o, redirect_o);
    end
    peek(12'h344);
    checks++;
    if (csr_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_pending_lost: got %h expected 00000000", csr_rdata_o);
    end
  endtask

  task automatic test_random();
    logic [11:0] addrs[8];
    logic [31:0] wd, want;
    addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h340, 12'h7C0};
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0:       wd = 32'h0;
        1:       wd = 32'h8 << ($urandom_range(0, 1) * 4);
        2:       wd = 32'h88;
        default: wd = $urandom;
      endcase
      instr_valid_i = ($urandom_range(0, 3) != 0);
      pc_i          = $urandom;
      csr_op_i      = 2'($urandom_range(0, 3));
      csr_addr_i    = addrs[$urandom_range(0, 7)];
      csr_wdata_i   = wd;
      is_mret_i     = ($urandom_range(0, 9) == 0);
      timer_intr_i  = ($urandom_range(0, 7) == 0);
      #1;
      want = model_read(csr_addr_i);
      checks++;
      if (csr_rdata_o !== want) begin
        errors++;
        $display("FAIL rand_rdata_%h: got %h expected %h at %0t", csr_addr_i, csr_rdata_o, want, $time);
      end
      @(posedge clk); #1;
    end
    idle(3);
  endtask

  initial begin
    reset = 1;
    instr_valid_i = 0; pc_i = 0; csr_op_i = 0; csr_addr_i = 0;
    csr_wdata_i = 0; is_mret_i = 0; timer_intr_i = 0;
    test_reset();
    test_trap_direct();
    test_masked();
    test_vectored();
    test_mret();
    test_back_to_back();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d queued redirects expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_intr_unit.md
Name: csr_intr_unit

Overview:
- Machine-mode CSR and trap unit for the 3-stage RV32I core.
- Consumes the timer interrupt pulse and latches it into mip.MTIP.
- Gates the pending interrupt with mstatus.MIE and mie.MTIE, performs trap entry (mepc/mcause/mstatus update, PC redirect to mtvec) and mret return.
- Sits beside the MEM/WB stage; also services Zicsr read/write/set/clear.

Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- FLUSH_CYCLES, 2, cycles after a redirect during which no new trap or mret is accepted (pipeline drain).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- timer_intr_i  in  1  timer interrupt pulse/level; any cycle high sets pending
- instr_valid_i  in  1  instruction in MEM/WB stage is valid (not bubble/flushed)
- pc_i  in  32  PC of that instruction
- csr_op_i  in  2  0 none, 1 write, 2 set, 3 clear
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  32  rs1/uimm operand
- is_mret_i  in  1  instruction is mret
- csr_rdata_o  out  32  combinational read of csr_addr_i (old value)
- redirect_o  out  1  registered, one-cycle PC redirect/flush request
- redirect_pc_o  out  32  target PC, valid when redirect_o=1
- trap_busy_o  out  1  high while state is FLUSH

Behaviour:
- Supported CSRs:
  - mstatus 0x300: MIE bit3, MPIE bit7; other bits read 0.
  - mie 0x304: MTIE bit7 only.
  - mtvec 0x305: bits[1:0] mode, 0 direct, 1 vectored.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342.
  - mip 0x344: MTIP bit7, read-only; writes ignored.
  - Unmapped addresses read 0; writes to them are ignored.
- Reset: all CSRs 0, mtvec=MTVEC_RESET, pending=0, state RUN, redirect_o=0, redirect_pc_o=0, trap_busy_o=0.
- Pending: MTIP<=1 on any cycle timer_intr_i=1. Cleared only on trap entry, unless timer_intr_i=1 in the same cycle, in which case set wins.
- take_intr = state RUN & instr_valid_i & MTIP & MIE & MTIE.
- take_mret = state RUN & instr_valid_i & is_mret_i & !take_intr.
- Trap entry, on the edge ending the take_intr cycle:
  - mepc<=pc_i; mcause<=32'h8000_0007; MPIE<=MIE; MIE<=0.
  - redirect_o=1 next cycle. redirect_pc_o = mtvec base in direct mode, base+28 in vectored mode.
  - The interrupted instruction does not retire: its CSR write is suppressed.
- mret: MIE<=MPIE; MPIE<=1; redirect_o=1 next cycle with redirect_pc_o=mepc.
- CSR access: write/set/clear applies at the clock edge when instr_valid_i=1, state RUN and no take_intr.
  - csr_op=set/clear with wdata=0 performs no write.
  - A write to mstatus in the same cycle as take_mret: the mret update wins.
- FSM:
  - RUN -> FLUSH on take_intr or take_mret.
  - FLUSH lasts FLUSH_CYCLES cycles (counter), then returns to RUN.
  - In FLUSH: instr_valid_i is ignored, no CSR writes, no traps, no mret. Pending still latches.
- redirect_o is high exactly one cycle: the first FLUSH cycle.
- Reset mid-FLUSH: returns to RUN immediately; pending is lost.
- csr_rdata_o is combinational and shows pre-update values.

Decomposition:
- Shared package csr_pkg:
  - CSR address localparams.
  - csr_op_e enum.
  - Bit-index constants MIE_BIT=3, MPIE_BIT=7, MTIE_BIT=7, MTIP_BIT=7.
  - CAUSE_M_TIMER=32'h8000_0007.
  - intr_state_e {RUN, FLUSH}.
- One sub-module, csr_regfile: storage, read mux, write/set/clear masking.
- Top-level csr_intr_unit: pending latch, take logic, FSM, redirect register.

Test Plan:
- Reset then read 0x305 -> MTVEC_RESET; 0x300, 0x304, 0x344 read 0.
- Write mtvec=0x100, mie=0x80, set mstatus bit3. Pulse timer_intr_i one cycle with pc_i=0x40 valid -> next cycle redirect_o=1, redirect_pc_o=0x100. Then mepc=0x40, mcause=0x80000007, mstatus=0x80, mip=0.
- Same as above but MIE=0 -> no redirect and mip reads 0x80 sticky. Later set MIE -> trap taken on the first valid instruction.
- Vectored mtvec=0x101 -> redirect_pc_o=0x11C.
- mret with mepc=0x44 after a trap -> redirect_pc_o=0x44, mstatus=0x88. No trap accepted for FLUSH_CYCLES cycles even with pending set.
- Timer pulse coinciding with the trap-entry edge -> mip stays 0x80 after entry; a second trap fires after mret+FLUSH. Reset asserted in FLUSH -> trap_busy_o=0 next cycle.
